// File: rtl/stopwatch_digit_gen_if.sv
// Control pulses into, and display/status signals out of, the stopwatch core.
interface stopwatch_digit_gen_if;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [6:0] digit0_segments;
   logic [6:0] digit1_segments;
   logic [6:0] digit2_segments;
   logic [6:0] digit3_segments;
   logic       running;
   logic       lap_active;
   logic       rollover;

   // Controller side: issues the pulses and watches the display outputs
   modport master (
      output start_stop, clear, lap,
      input  digit0_segments, digit1_segments, digit2_segments, digit3_segments,
      input  running, lap_active, rollover
   );

   // Stopwatch core side
   modport slave (
      input  start_stop, clear, lap,
      output digit0_segments, digit1_segments, digit2_segments, digit3_segments,
      output running, lap_active, rollover
   );
endinterface

// File: rtl/stopwatch_digit_gen.sv
// MM:SS stopwatch core: one-second prescaler, BCD count, run/pause/clear
// control, lap display hold and registered seven-segment digit patterns.
module stopwatch_digit_gen #(
   parameter int TICK_DIV = 100000000
) (
   input logic                 clk,
   input logic                 rst,
   stopwatch_digit_gen_if.slave bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t        state_q;
   logic [PW-1:0] presc_q;
   logic [3:0]    s1_q, s10_q, m1_q, m10_q;
   logic [3:0]    snapS1_q, snapS10_q, snapM1_q, snapM10_q;
   logic          hold_q;
   logic [6:0]    seg0_q, seg1_q, seg2_q, seg3_q;
   logic          running_q, lapActive_q, rollover_q;

   logic [3:0]    s1_d, s10_d, m1_d, m10_d;
   logic [3:0]    show0, show1, show2, show3;
   logic          tick, atMax;

   // Active-high a..g pattern for one BCD digit
   function automatic logic [6:0] encodeDigit(input logic [3:0] d);
      logic [6:0] seg;
      case (d)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   // Terminal-count detect, ripple-carry BCD increment and display source select
   always_comb begin
      tick  = (state_q == RUN) && (presc_q == TERM);
      atMax = (s1_q == 4'd9) && (s10_q == 4'd5) && (m1_q == 4'd9) && (m10_q == 4'd5);
      s1_d  = s1_q;
      s10_d = s10_q;
      m1_d  = m1_q;
      m10_d = m10_q;
      if (s1_q != 4'd9) begin
         s1_d = s1_q + 4'd1;
      end else begin
         s1_d = 4'd0;
         if (s10_q != 4'd5) begin
            s10_d = s10_q + 4'd1;
         end else begin
            s10_d = 4'd0;
            if (m1_q != 4'd9) begin
               m1_d = m1_q + 4'd1;
            end else begin
               m1_d = 4'd0;
               if (m10_q != 4'd5) begin
                  m10_d = m10_q + 4'd1;
               end else begin
                  m10_d = 4'd0;
               end
            end
         end
      end
      show0 = hold_q ? snapS1_q  : s1_q;
      show1 = hold_q ? snapS10_q : s10_q;
      show2 = hold_q ? snapM1_q  : m1_q;
      show3 = hold_q ? snapM10_q : m10_q;
   end

   // Control FSM with count, prescaler, lap hold and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         presc_q     <= '0;
         s1_q        <= 4'd0;
         s10_q       <= 4'd0;
         m1_q        <= 4'd0;
         m10_q       <= 4'd0;
         snapS1_q    <= 4'd0;
         snapS10_q   <= 4'd0;
         snapM1_q    <= 4'd0;
         snapM10_q   <= 4'd0;
         hold_q      <= 1'b0;
         seg0_q      <= 7'h3F;
         seg1_q      <= 7'h3F;
         seg2_q      <= 7'h3F;
         seg3_q      <= 7'h3F;
         running_q   <= 1'b0;
         lapActive_q <= 1'b0;
         rollover_q  <= 1'b0;
      end else begin
         rollover_q <= 1'b0;

         if (state_q == RUN) begin
            if (tick) begin
               presc_q    <= '0;
               s1_q       <= s1_d;
               s10_q      <= s10_d;
               m1_q       <= m1_d;
               m10_q      <= m10_d;
               rollover_q <= atMax;
            end else begin
               presc_q <= presc_q + PW'(1);
            end
         end

         if (bus.lap) begin
            if (hold_q) begin
               if (state_q != IDLE) begin
                  hold_q      <= 1'b0;
                  lapActive_q <= 1'b0;
               end
            end else if (state_q == RUN) begin
               hold_q      <= 1'b1;
               lapActive_q <= 1'b1;
               snapS1_q    <= s1_q;
               snapS10_q   <= s10_q;
               snapM1_q    <= m1_q;
               snapM10_q   <= m10_q;
            end
         end

         case (state_q)
            IDLE, PAUSE: begin
               if (bus.clear) begin
                  state_q     <= IDLE;
                  running_q   <= 1'b0;
                  presc_q     <= '0;
                  s1_q        <= 4'd0;
                  s10_q       <= 4'd0;
                  m1_q        <= 4'd0;
                  m10_q       <= 4'd0;
                  hold_q      <= 1'b0;
                  lapActive_q <= 1'b0;
               end else if (bus.start_stop) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            RUN: begin
               if (bus.start_stop) begin
                  state_q   <= PAUSE;
                  running_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               running_q <= 1'b0;
            end
         endcase

         seg0_q <= encodeDigit(show0);
         seg1_q <= encodeDigit(show1);
         seg2_q <= encodeDigit(show2);
         seg3_q <= encodeDigit(show3);
      end
   end

   assign bus.digit0_segments = seg0_q;
   assign bus.digit1_segments = seg1_q;
   assign bus.digit2_segments = seg2_q;
   assign bus.digit3_segments = seg3_q;
   assign bus.running         = running_q;
   assign bus.lap_active      = lapActive_q;
   assign bus.rollover        = rollover_q;

endmodule
